axi_rd_slave_responder: RTL and testbench



---
 rtl/axi_rd_slave_responder_if.sv | 38 +++
 rtl/axi_rd_slave_responder.sv | 134 +++++++++++++
 tb/tb_axi_rd_slave_responder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_rd_slave_responder_if.sv
// AXI4 read-address / read-data channel bundle for axi_rd_slave_responder.
// Handshake rule for both channels: a transfer happens on the rising clk
// edge where valid and ready are both high. Once valid is raised, the source
// holds valid and its payload unchanged until that edge. Ready may be raised
// or dropped at any time.
// Ports (signals):
//   AR: arid, araddr, arlen, arsize, arburst, arvalid (master->slave), arready (slave->master)
//   R : rid, rdata, rresp, rlast, rvalid (slave->master), rready (master->slave)
interface axi_rd_slave_responder_if #(
  parameter int ID_W   = 12,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_rd_slave_responder.sv
// AXI4 read slave. Accepts one AR burst at a time, walks the burst address
// (FIXED / INCR / WRAP), reads each beat from a 1-cycle-latency word memory
// and returns R beats with rid / rresp / rlast. Illegal requests are answered
// with len+1 SLVERR beats of zero data without touching the memory.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   s_axi      : AR/R channels (slave modport)
//   mem_en     : word read strobe
//   mem_addr   : word-aligned byte address of the read
//   mem_rdata  : read data, valid the cycle after mem_en
//   dbg_state  : current FSM state (IDLE=0, REQ=1, CAP=2, RESP=3)
module axi_rd_slave_responder #(
  parameter int ID_W   = 12,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  axi_rd_slave_responder_if.slave s_axi,
  output logic                 mem_en,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic [1:0]           dbg_state
);
  localparam int BPW   = DATA_W / 8;
  localparam int MAXSZ = $clog2(BPW);

  typedef enum logic [1:0] {IDLE, REQ, CAP, RESP} state_t;

  state_t            state, state_next;
  logic              arready_q;
  logic [ID_W-1:0]   rid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;
  logic              rlast_q;
  logic [7:0]        beat_q;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic              err_q;
  logic [ADDR_W-1:0] cur_addr;

  logic              ar_hs;
  logic              r_hs;
  logic              err_in;
  logic [ADDR_W-1:0] beat_bytes;
  logic [ADDR_W-1:0] wrap_mask;
  logic [ADDR_W-1:0] addr_next;

  assign ar_hs = s_axi.arvalid && arready_q;
  assign r_hs  = (state == RESP) && s_axi.rready;

  // Request legality, evaluated on the live AR payload.
  assign err_in = (s_axi.arsize > 3'(MAXSZ)) ||
                  (s_axi.arburst == 2'b11) ||
                  ((s_axi.arburst == 2'b10) &&
                   !((s_axi.arlen == 8'd1) || (s_axi.arlen == 8'd3) ||
                     (s_axi.arlen == 8'd7) || (s_axi.arlen == 8'd15)));

  // Next beat address. For a legal WRAP, len+1 is a power of two, so the
  // wrap window minus one is simply (len << size) | (bytes_per_beat - 1).
  always_comb begin
    beat_bytes = ADDR_W'(1) << size_q;
    wrap_mask  = (ADDR_W'(len_q) << size_q) | (beat_bytes - ADDR_W'(1));
    addr_next  = cur_addr;
    case (burst_q)
      2'b00:   addr_next = cur_addr;
      2'b10:   addr_next = (cur_addr & ~wrap_mask) | ((cur_addr + beat_bytes) & wrap_mask);
      default: addr_next = (cur_addr & ~(beat_bytes - ADDR_W'(1))) + beat_bytes;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ar_hs) state_next = REQ;
      REQ:     state_next = CAP;
      CAP:     state_next = RESP;
      RESP:    if (r_hs) state_next = rlast_q ? IDLE : REQ;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      arready_q <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      rlast_q   <= 1'b0;
      beat_q    <= 8'd0;
      len_q     <= 8'd0;
      size_q    <= 3'd0;
      burst_q   <= 2'b00;
      err_q     <= 1'b0;
      cur_addr  <= '0;
    end else begin
      state <= state_next;
      // Registered ready: low in the first idle cycle after reset, and
      // high again the cycle after the last R handshake.
      arready_q <= (state_next == IDLE);
      if (ar_hs) begin
        rid_q    <= s_axi.arid;
        cur_addr <= s_axi.araddr;
        len_q    <= s_axi.arlen;
        size_q   <= s_axi.arsize;
        burst_q  <= s_axi.arburst;
        err_q    <= err_in;
        beat_q   <= 8'd0;
      end
      if (state == CAP) begin
        rdata_q <= err_q ? '0 : mem_rdata;
        rresp_q <= err_q ? 2'b10 : 2'b00;
        rlast_q <= (beat_q == len_q);
      end
      if (r_hs && !rlast_q) begin
        beat_q   <= beat_q + 8'd1;
        cur_addr <= addr_next;
      end
    end
  end

  assign mem_en    = (state == REQ) && !err_q;
  assign mem_addr  = {cur_addr[ADDR_W-1:MAXSZ], {MAXSZ{1'b0}}};
  assign dbg_state = state;

  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = (state == RESP);
  assign s_axi.rid     = rid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rlast   = rlast_q;
endmodule

// File: tb/tb_axi_rd_slave_responder.sv
// Bench for axi_rd_slave_responder: directed bursts, backpressure, reset
// mid-burst and randomized bursts, each beat compared against a closed-form
// per-beat address model and a {addr, ~addr} word memory.
module tb_axi_rd_slave_responder;
  localparam int ID_W   = 12;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  axi_rd_slave_responder_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_axi ();
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [1:0]        dbg_state;

  axi_rd_slave_responder #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_axi     (s_axi),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .dbg_state (dbg_state)
  );

  // Word memory: 1-cycle latency, content {address, ~address}.
  always @(posedge clk) if (mem_en) mem_rdata <= {mem_addr, ~mem_addr};

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic model_err(input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
    return (size > 3'd3) || (burst == 2'b11) ||
           ((burst == 2'b10) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
  endfunction

  // Byte address of beat i, computed directly from the start address.
  function automatic logic [31:0] model_addr(input logic [31:0] a, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] burst,
                                             input int i);
    logic [31:0] bb, w, base;
    bb = 32'd1 << size;
    w  = bb * (32'(len) + 32'd1);
    if (burst == 2'b00) return a;
    if (burst == 2'b10) begin
      base = a - (a % w);
      return base + ((a + 32'(i) * bb) % w);
    end
    if (i == 0) return a;
    return (a - (a % bb)) + 32'(i) * bb;
  endfunction

  // ---------------- driver ----------------
  task automatic run_burst(input logic [ID_W-1:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int stall_lo,
                           input int stall_hi, input int abort_at);
    logic        err;
    logic [31:0] ma;
    logic [63:0] exp_data;
    logic [1:0]  exp_resp;
    logic        exp_last;
    logic        saw;
    int          k, t_ref, st;
    err = model_err(len, size, burst);

    @(negedge clk);
    s_axi.arid    = id;
    s_axi.araddr  = addr;
    s_axi.arlen   = len;
    s_axi.arsize  = size;
    s_axi.arburst = burst;
    s_axi.arvalid = 1'b1;
    k = 0;
    while (s_axi.arready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("ar_ready", s_axi.arready, 1'b1);
    t_ref = cyc;
    @(negedge clk);
    s_axi.arvalid = 1'b0;

    for (int i = 0; i <= int'(len); i++) begin
      ma       = model_addr(addr, len, size, burst, i) & ~32'd7;
      exp_data = err ? 64'd0 : {ma, ~ma};
      exp_resp = err ? 2'b10 : 2'b00;
      exp_last = (i == int'(len));
      saw = 1'b0;
      k = 0;
      while (s_axi.rvalid !== 1'b1 && k < 8) begin
        if (mem_en === 1'b1) begin
          saw = 1'b1;
          check("mem_addr", mem_addr, ma);
          check("mem_en_cycle", cyc, t_ref + 1);
        end
        @(negedge clk);
        k++;
      end
      check("rvalid_seen", s_axi.rvalid, 1'b1);
      check("r_latency", cyc, t_ref + 3);
      check("mem_en_used", saw, !err);
      check("rid", s_axi.rid, id);
      check("rdata", s_axi.rdata, exp_data);
      check("rresp", s_axi.rresp, exp_resp);
      check("rlast", s_axi.rlast, exp_last);
      if (i == abort_at) begin
        s_axi.rready = 1'b0;
        return;
      end

      st = $urandom_range(stall_hi, stall_lo);
      if (st > 0) begin
        s_axi.rready = 1'b0;
        for (int s = 0; s < st; s++) begin
          if (s == 0) begin
            s_axi.arvalid = 1'b1;
            s_axi.arid    = ~id;
            s_axi.araddr  = $urandom;
            s_axi.arlen   = 8'd0;
          end
          @(negedge clk);
          check("busy_arready", s_axi.arready, 1'b0);
          s_axi.arvalid = 1'b0;
          check("stall_rvalid", s_axi.rvalid, 1'b1);
          check("stall_rdata", s_axi.rdata, exp_data);
          check("stall_rlast", s_axi.rlast, exp_last);
          check("stall_rresp", s_axi.rresp, exp_resp);
          check("stall_rid", s_axi.rid, id);
          check("stall_mem_en", mem_en, 1'b0);
        end
      end
      s_axi.rready = 1'b1;
      t_ref = cyc;
      @(negedge clk);
    end
    check("done_rvalid", s_axi.rvalid, 1'b0);
    check("done_arready", s_axi.arready, 1'b1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_arready"}, s_axi.arready, 1'b0);
    check({tag, "_rvalid"}, s_axi.rvalid, 1'b0);
    check({tag, "_rlast"}, s_axi.rlast, 1'b0);
    check({tag, "_rid"}, s_axi.rid, '0);
    check({tag, "_rdata"}, s_axi.rdata, '0);
    check({tag, "_rresp"}, s_axi.rresp, 2'b00);
    check({tag, "_mem_en"}, mem_en, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  logic [1:0]  r_burst;
  logic [2:0]  r_size;
  logic [7:0]  r_len;
  logic [31:0] r_addr;

  initial begin
    s_axi.arid    = '0;
    s_axi.araddr  = '0;
    s_axi.arlen   = '0;
    s_axi.arsize  = '0;
    s_axi.arburst = '0;
    s_axi.arvalid = 1'b0;
    s_axi.rready  = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_arready", s_axi.arready, 1'b1);

    // Single beat INCR.
    run_burst(12'h5, 32'h100, 8'd0, 3'd3, 2'b01, 0, 0, -1);
    // INCR 4 beats, narrow, rready held high.
    s_axi.rready = 1'b1;
    run_burst(12'h21, 32'h1004, 8'd3, 3'd2, 2'b01, 0, 0, -1);
    // WRAP and FIXED.
    run_burst(12'h33, 32'h38, 8'd3, 3'd3, 2'b10, 0, 0, -1);
    run_burst(12'h44, 32'h40, 8'd2, 3'd3, 2'b00, 0, 1, -1);
    // INCR crossing the top of the address space.
    run_burst(12'h55, 32'hFFFF_FFF0, 8'd3, 3'd3, 2'b01, 0, 0, -1);
    // Errors.
    run_burst(12'h66, 32'h200, 8'd1, 3'd4, 2'b01, 0, 0, -1);
    run_burst(12'h77, 32'h300, 8'd2, 3'd3, 2'b10, 0, 0, -1);
    run_burst(12'h88, 32'h400, 8'd1, 3'd2, 2'b11, 0, 0, -1);
    // Backpressure: 5 stalled cycles on every beat.
    run_burst(12'h99, 32'h800, 8'd2, 3'd3, 2'b01, 5, 5, -1);
    // Longest INCR burst.
    run_burst(12'hABC, 32'h1_0000, 8'd255, 3'd3, 2'b01, 0, 0, -1);

    // Reset in the middle of a burst, with rvalid high and rready low.
    run_burst(12'hBB, 32'h2000, 8'd7, 3'd3, 2'b01, 0, 0, 2);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("midrst");
    rst = 1'b0;
    @(negedge clk);
    check("midrst_arready_then", s_axi.arready, 1'b1);
    check("midrst_rvalid_then", s_axi.rvalid, 1'b0);
    run_burst(12'hCC, 32'h3000, 8'd3, 3'd3, 2'b01, 0, 0, -1);

    // Randomized bursts.
    for (int n = 0; n < 14; n++) begin
      r_burst = ($urandom_range(9, 0) == 0) ? 2'b11 : 2'($urandom_range(2, 0));
      r_size  = ($urandom_range(7, 0) == 0) ? 3'($urandom_range(7, 4)) : 3'($urandom_range(3, 0));
      if (r_burst == 2'b10 && $urandom_range(4, 0) != 0)
        r_len = 8'((1 << $urandom_range(4, 1)) - 1);
      else
        r_len = 8'($urandom_range(15, 0));
      r_addr = $urandom;
      if (r_burst == 2'b10) r_addr = r_addr & ~((32'd1 << r_size) - 32'd1);
      s_axi.rready = 1'($urandom_range(1, 0));
      run_burst(12'($urandom), r_addr, r_len, r_size, r_burst, 0, 2, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
